// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with sweep-based debounce and decimal entry of up to four digits.
// States: IDLE | no key held; PRESS_CAND | key seen, counting stable sweeps; HELD | key accepted, waiting release; REL_CAND | counting empty sweeps
module keypad_entry #(
    parameter int SCAN_OVERFLOW  = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col_select,
    input  logic [3:0]  row_sense,
    output logic        key_strobe,
    output logic [3:0]  key_code,
    output logic        op_strobe,
    output logic [1:0]  op_code,
    output logic        nr_valid,
    output logic [13:0] entered_nr
);

    localparam int SW = $clog2(SCAN_OVERFLOW);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_OVERFLOW - 1);
    localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);

    typedef enum logic [1:0] {IDLE, PRESS_CAND, HELD, REL_CAND} state_t;

    state_t        state;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    col;
    logic          acc_seen;
    logic          acc_multi;
    logic [3:0]    acc_pos;
    logic [DW-1:0] deb_cnt;
    logic [3:0]    cand;
    logic [2:0]    digit_count;
    logic          new_entry;

    logic [2:0]    low_cnt;
    logic [1:0]    low_idx;
    logic          sample_tick;
    logic          sweep_done;
    logic          next_seen;
    logic          next_multi;
    logic [3:0]    next_pos;
    logic          sweep_key;
    logic [3:0]    sweep_code;
    logic          accept;
    logic [13:0]   times_ten;

    function automatic logic [3:0] key_map(input logic [3:0] pos);
        logic [3:0] code;
        case (pos)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    always_comb begin
        low_cnt = 3'd0;
        low_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sense[r]) begin
                low_cnt = low_cnt + 3'd1;
                low_idx = 2'(r);
            end
        end
    end

    assign sample_tick = (scan_cnt == SCAN_LAST);
    assign sweep_done  = sample_tick && (col == 2'd3);

    // Sweep result folds in the column being sampled right now.
    assign next_seen  = acc_seen | (low_cnt != 3'd0);
    assign next_multi = acc_multi | (low_cnt > 3'd1) | (acc_seen & (low_cnt != 3'd0));
    assign next_pos   = (!acc_seen && low_cnt == 3'd1) ? {low_idx, col} : acc_pos;
    assign sweep_key  = next_seen & ~next_multi;
    assign sweep_code = key_map(next_pos);

    always_comb begin
        accept = 1'b0;
        if (sweep_done && sweep_key) begin
            case (state)
                IDLE:       accept = (DEB_TARGET == DEB_ONE);
                PRESS_CAND: accept = (sweep_code == cand) && (deb_cnt + DEB_ONE == DEB_TARGET);
                default:    accept = 1'b0;
            endcase
        end
    end

    assign times_ten = (entered_nr << 3) + (entered_nr << 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt   <= '0;
            col        <= 2'd0;
            col_select <= 4'b1110;
            acc_seen   <= 1'b0;
            acc_multi  <= 1'b0;
            acc_pos    <= 4'd0;
        end else if (sample_tick) begin
            scan_cnt   <= '0;
            col        <= col + 2'd1;
            col_select <= {col_select[2:0], col_select[3]};
            if (col == 2'd3) begin
                acc_seen  <= 1'b0;
                acc_multi <= 1'b0;
                acc_pos   <= 4'd0;
            end else begin
                acc_seen  <= next_seen;
                acc_multi <= next_multi;
                acc_pos   <= next_pos;
            end
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            cand        <= 4'd0;
            entered_nr  <= 14'd0;
            digit_count <= 3'd0;
            new_entry   <= 1'b0;
            key_code    <= 4'd0;
            op_code     <= 2'd0;
            key_strobe  <= 1'b0;
            op_strobe   <= 1'b0;
            nr_valid    <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            op_strobe  <= 1'b0;
            nr_valid   <= 1'b0;

            if (sweep_done) begin
                case (state)
                    IDLE: begin
                        if (sweep_key) begin
                            cand    <= sweep_code;
                            deb_cnt <= DEB_ONE;
                            state   <= accept ? HELD : PRESS_CAND;
                        end
                    end
                    PRESS_CAND: begin
                        if (!sweep_key) begin
                            state <= IDLE;
                        end else if (sweep_code != cand) begin
                            cand    <= sweep_code;
                            deb_cnt <= DEB_ONE;
                        end else if (accept) begin
                            state <= HELD;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_ONE;
                        end
                    end
                    HELD: begin
                        if (!sweep_key) begin
                            deb_cnt <= DEB_ONE;
                            state   <= (DEB_TARGET == DEB_ONE) ? IDLE : REL_CAND;
                        end
                    end
                    default: begin
                        if (sweep_key) begin
                            state <= HELD;
                        end else if (deb_cnt + DEB_ONE == DEB_TARGET) begin
                            state <= IDLE;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_ONE;
                        end
                    end
                endcase
            end

            if (accept) begin
                key_strobe <= 1'b1;
                key_code   <= sweep_code;
                if (sweep_code <= 4'd9) begin
                    if (new_entry) begin
                        entered_nr  <= {10'd0, sweep_code};
                        digit_count <= 3'd1;
                        new_entry   <= 1'b0;
                    end else if (digit_count < 3'd4) begin
                        entered_nr  <= times_ten + {10'd0, sweep_code};
                        digit_count <= digit_count + 3'd1;
                    end
                end else if (sweep_code == 4'd14) begin
                    entered_nr  <= 14'd0;
                    digit_count <= 3'd0;
                    new_entry   <= 1'b0;
                end else if (sweep_code == 4'd15) begin
                    nr_valid  <= 1'b1;
                    new_entry <= 1'b1;
                end else begin
                    op_strobe <= 1'b1;
                    op_code   <= 2'(sweep_code - 4'd10);
                    new_entry <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Scans a 4x4 matrix keypad and debounces it. Decodes each key press and assembles up to four decimal digits into a 14-bit number (0..9999). This is the input side of the calculator; the result feeds the arithmetic core and the 7-segment display driver, whose number input is also 14 bits. Operator, clear and enter keys are reported as single-cycle strobes.

Parameters:
SCAN_OVERFLOW, 50000, clk cycles each column is driven before advancing (>=2)
DEBOUNCE_SCANS, 4, consecutive full sweeps a key state must be stable to be accepted (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
col_select  output  4  keypad column drive, one-hot active-low
row_sense  input  4  keypad row inputs, active-low (externally pulled up)
key_strobe  output  1  one-cycle pulse per accepted key press
key_code  output  4  code of last accepted key: 0-9 digit, A=10, B=11, C=12, D=13, *=14, #=15
op_strobe  output  1  one-cycle pulse when A/B/C/D is accepted
op_code  output  2  A=0, B=1, C=2, D=3; valid with op_strobe, held afterwards
nr_valid  output  1  one-cycle pulse when # is accepted
entered_nr  output  14  number being entered, binary 0..9999

Behaviour:
- Reset (reset=0 at clk edge): col_select=4'b1110; scan counter, column index, sweep latch and debounce counters cleared; FSM=IDLE; entered_nr=0; digit_count=0; new_entry=0; key_code=0; op_code=0; all strobes 0. Reset mid-scan or mid-debounce abandons the pending key; no strobe is produced.
- Keymap (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Scan:
  - Counter runs 0..SCAN_OVERFLOW-1 per column. row_sense is sampled on the count=SCAN_OVERFLOW-1 edge, then the column advances 0→1→2→3→0.
  - A sweep is 4*SCAN_OVERFLOW cycles. The sweep result is evaluated on the sample edge of column 3.
  - Sweep result is one of: NONE (no low rows); KEY(k) (exactly one low row over the whole sweep); MULTI (more than one). MULTI is treated as NONE.
- Debounce FSM (advances once per sweep):
  - IDLE: KEY(k) → PRESS_CAND with cand=k, cnt=1.
  - PRESS_CAND:
    - same k → cnt+1;
    - different key → restart with new cand, cnt=1;
    - NONE → IDLE.
    - When cnt reaches DEBOUNCE_SCANS → HELD and the key is accepted.
  - HELD: NONE → REL_CAND with cnt=1; any KEY → stay in HELD (no auto-repeat, no rollover).
  - REL_CAND: NONE → cnt+1, reaching DEBOUNCE_SCANS → IDLE; any KEY → HELD.
  - With DEBOUNCE_SCANS=1, acceptance happens on the first KEY sweep.
- Acceptance latency: strobes are high exactly one cycle, the cycle after the accepting sweep edge. key_code and entered_nr update on that same edge.
- Entry rules on acceptance:
  - Digit d:
    - if new_entry=1: entered_nr=d, digit_count=1, new_entry=0;
    - else if digit_count<4: entered_nr=entered_nr*10+d, digit_count+1;
    - else ignored (key_strobe still pulses, entered_nr unchanged).
    - Multiply via (x<<3)+(x<<1); the result always fits in 14 bits.
  - *: entered_nr=0, digit_count=0, new_entry=0.
  - #: nr_valid pulse; entered_nr held; new_entry=1.
  - A-D: op_strobe pulse with op_code; entered_nr held; new_entry=1.
- Leading zeros: a leading 0 digit counts toward digit_count; entered_nr stays 0.
- Exactly one of {digit, *, #, op} takes effect per acceptance. Strobes never overlap across accepted keys.

Test Plan:
All tests use SCAN_OVERFLOW=4, DEBOUNCE_SCANS=2 (sweep = 16 cycles).
- Reset: hold reset=0 for 3 cycles → col_select=1110, entered_nr=0, strobes 0. After release, col_select steps 1110→1101→1011→0111 every 4 cycles.
- Press 5 (row1 low while column1 is driven) for 3 sweeps → exactly one key_strobe with key_code=5, entered_nr=5. Release, then press 4, 2, 3 → entered_nr=5423. Press 7 → key_strobe pulses, entered_nr stays 5423.
- Bounce: key 8 present for 1 sweep, absent 1 sweep, repeated → no strobe. Held for 2 sweeps → strobe with key_code=8.
- Two keys in the same sweep (rows 0 and 1 low in column 0) → no strobe, FSM stays IDLE.
- Enter 1432, press # → nr_valid pulses for 1 cycle with entered_nr=1432. Then press 8 → entered_nr=8. Press * → entered_nr=0.
- Enter 12, press B → op_strobe with op_code=1, entered_nr=12. Assert reset while key 9 is in PRESS_CAND → no strobe, entered_nr=0.
